alu_seq_exec: RTL and testbench
===============================

Name: alu_seq_exec

Overview:
- Multi-cycle execute unit for the RV64 datapath. It is the consumer of the 5-bit ALU control code produced by the ALU decoder.
- Accepts operands plus a control code over a valid/ready handshake.
- Single-cycle ops: add/sub/logic/compare/W-add. Shifts are iterative, one bit position per cycle.
- Result and zero flag are held until the downstream multi-cycle FSM accepts them.

Parameters:
- XLEN, 64, datapath width; only 64 is legal, because W ops sign-extend from bit 31.
- CTRL_W, 5, width of the ALU control code.

Ports:
- i_clk  input  1  clock.
- i_arstn  input  1  asynchronous active-low reset.
- i_valid  input  1  request valid.
- o_ready  output  1  unit idle, can accept a request.
- i_alu_control  input  CTRL_W  operation code.
- i_src_a  input  XLEN  operand A (shift source).
- i_src_b  input  XLEN  operand B (shift amount in low bits).
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts result.
- o_result  output  XLEN  registered result.
- o_zero  output  1  registered (o_result == 0), used for beq/bne via SUB.

Behaviour:
- Codes:
  - 00000 ADD, 00001 SUB, 00010 AND, 00011 OR, 00100 XOR, 00101 SLL.
  - 00110 SLT (signed, result 0/1), 00111 SLTU.
  - 01000 SRL, 01001 SRA, 01010 SLLI, 01011 SRLI, 01100 SRAI.
  - 01101 ADDW, 01110 SUBW, 01111 SLLW/SLLIW, 10000 SRLW/SRLIW, 10001 SRAW/SRAIW, 10010 ADDIW.
  - Any other code: result 0, handled as a single-cycle op.
- Reset (async, i_arstn=0): state IDLE; o_ready=1, o_valid=0, o_result=0, o_zero=1, shift counter 0. Reset mid-shift aborts the operation and discards it; no output is produced.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: o_ready=1. Accept when i_valid=1.
  - Non-shift op: result computed combinationally and registered; go to DONE. o_valid=1 exactly 1 cycle after accept.
  - Shift op: load shift register and counter, then:
    - shamt=0: go straight to DONE.
    - otherwise go to SHIFT. o_valid rises shamt+1 cycles after accept.
- Shift amount:
  - 64-bit shifts (SLL/SRL/SRA/SLLI/SRLI/SRAI): src_b[5:0].
  - W shifts: src_b[4:0].
- Shift register load value:
  - SLL, SLLW: src_a.
  - SRL: src_a.
  - SRA: src_a.
  - SRLW: zero-extended src_a[31:0].
  - SRAW: sign-extended src_a[31:0].
- SHIFT: each cycle shift one position (left fills 0; logical right fills 0; arithmetic right fills MSB) and decrement the counter. On the cycle the counter goes 1->0, register the final result and go to DONE.
- W results (ADDW, SUBW, ADDIW, all W shifts): sign-extend bit 31 of the 64-bit intermediate. ADDW and ADDIW compute identically.
- Arithmetic wraps modulo 2^XLEN; no overflow flag.
- DONE: o_valid=1, o_ready=0. o_result and o_zero are stable until i_ready=1; that handshake cycle returns to IDLE. There is no back-to-back accept: a new request is accepted no earlier than the cycle after o_valid drops.
- i_valid while not IDLE is ignored; the producer must hold the request until o_ready.
- Inputs are sampled only on the accept cycle; later changes to i_src_a, i_src_b or i_alu_control do not affect the result.
- o_zero is registered in the same cycle as o_result and always equals (o_result==0).

Decomposition:
- Package alu_pkg:
  - enum alu_ctrl_e with all 19 codes above (shared with the ALU decoder).
  - enum exec_state_e {IDLE, SHIFT, DONE}.
  - localparams SHAMT_W=6 and SHAMT_W_W=5.
- Sub-module alu_comb_unit: purely combinational single-cycle ops, including the W sign-extension.
- The FSM, shift register and counter stay in alu_seq_exec.

Test Plan:
- Reset then ADD, a=5, b=7 -> o_valid 1 cycle after accept; o_result=12; o_zero=0.
- SUB a=b=0x1234 with i_ready held low for 3 cycles -> o_result=0, o_zero=1, both stable for all 3 cycles; back to IDLE on the i_ready cycle.
- SRA a=0x8000_0000_0000_0000, b=4 -> o_valid 5 cycles after accept; o_result=0xF800_0000_0000_0000.
- SRLW a=0x0000_0000_8000_0000, b=0 -> o_valid 1 cycle after accept; o_result=0xFFFF_FFFF_8000_0000. SRLW b=1 on the same a -> o_result=0x0000_0000_4000_0000.
- ADDW a=0x7FFF_FFFF, b=1 -> o_result=0xFFFF_FFFF_8000_0000. SLTU a=1, b=-1 -> 1. SLT a=1, b=-1 -> 0.
- Start SLL with b=63, assert i_arstn=0 at cycle 10 -> o_valid=0, o_ready=1, o_result=0 immediately. After release, ADD 1+1 -> 2 with normal 1-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control codes, FSM states and shift helpers
package alu_pkg;

    localparam int DATA_W    = 64;
    localparam int SHAMT_W   = 6;
    localparam int SHAMT_W_W = 5;

    typedef enum logic [4:0] {
        ALU_ADD   = 5'b00000,
        ALU_SUB   = 5'b00001,
        ALU_AND   = 5'b00010,
        ALU_OR    = 5'b00011,
        ALU_XOR   = 5'b00100,
        ALU_SLL   = 5'b00101,
        ALU_SLT   = 5'b00110,
        ALU_SLTU  = 5'b00111,
        ALU_SRL   = 5'b01000,
        ALU_SRA   = 5'b01001,
        ALU_SLLI  = 5'b01010,
        ALU_SRLI  = 5'b01011,
        ALU_SRAI  = 5'b01100,
        ALU_ADDW  = 5'b01101,
        ALU_SUBW  = 5'b01110,
        ALU_SLLW  = 5'b01111,
        ALU_SRLW  = 5'b10000,
        ALU_SRAW  = 5'b10001,
        ALU_ADDIW = 5'b10010
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } exec_state_e;

    function automatic logic is_shift_op(input logic [4:0] ctrl);
        case (ctrl)
            ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLI, ALU_SRLI, ALU_SRAI,
            ALU_SLLW, ALU_SRLW, ALU_SRAW: is_shift_op = 1'b1;
            default:                      is_shift_op = 1'b0;
        endcase
    endfunction

    function automatic logic is_w_shift(input logic [4:0] ctrl);
        case (ctrl)
            ALU_SLLW, ALU_SRLW, ALU_SRAW: is_w_shift = 1'b1;
            default:                      is_w_shift = 1'b0;
        endcase
    endfunction

    function automatic logic is_w_op(input logic [4:0] ctrl);
        case (ctrl)
            ALU_ADDW, ALU_SUBW, ALU_ADDIW,
            ALU_SLLW, ALU_SRLW, ALU_SRAW: is_w_op = 1'b1;
            default:                      is_w_op = 1'b0;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] sext_w(input logic [DATA_W-1:0] v);
        sext_w = {{(DATA_W-32){v[31]}}, v[31:0]};
    endfunction

    // One bit position per call; the W variants rely on the load value already being 64-bit extended.
    function automatic logic [DATA_W-1:0] shift_one(input logic [4:0] ctrl,
                                                    input logic [DATA_W-1:0] v);
        case (ctrl)
            ALU_SLL, ALU_SLLI, ALU_SLLW: shift_one = {v[DATA_W-2:0], 1'b0};
            ALU_SRA, ALU_SRAI, ALU_SRAW: shift_one = {v[DATA_W-1], v[DATA_W-1:1]};
            default:                     shift_one = {1'b0, v[DATA_W-1:1]};
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_exec_if.sv
// rtl/alu_seq_exec_if.sv - request/result handshake bundle for the execute unit
interface alu_seq_exec_if #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 5
);
    logic              i_valid;
    logic              o_ready;
    logic [CTRL_W-1:0] i_alu_control;
    logic [XLEN-1:0]   i_src_a;
    logic [XLEN-1:0]   i_src_b;
    logic              o_valid;
    logic              i_ready;
    logic [XLEN-1:0]   o_result;
    logic              o_zero;

    modport master (
        output i_valid, i_alu_control, i_src_a, i_src_b, i_ready,
        input  o_ready, o_valid, o_result, o_zero
    );

    modport slave (
        input  i_valid, i_alu_control, i_src_a, i_src_b, i_ready,
        output o_ready, o_valid, o_result, o_zero
    );
endinterface

// File: rtl/alu_comb_unit.sv
// rtl/alu_comb_unit.sv - single-cycle ALU operations, including W sign-extension
module alu_comb_unit
    import alu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 5
) (
    input  logic [CTRL_W-1:0] alu_control,
    input  logic [XLEN-1:0]   src_a,
    input  logic [XLEN-1:0]   src_b,
    output logic [XLEN-1:0]   result
);

    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    // Shift codes fall into the default; the sequencer owns them.
    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD:             result = sum;
            ALU_SUB:             result = diff;
            ALU_AND:             result = src_a & src_b;
            ALU_OR:              result = src_a | src_b;
            ALU_XOR:             result = src_a ^ src_b;
            ALU_SLT:             result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SLTU:            result = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            ALU_ADDW, ALU_ADDIW: result = sext_w(sum);
            ALU_SUBW:            result = sext_w(diff);
            default:             result = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_exec.sv
// rtl/alu_seq_exec.sv - multi-cycle RV64 execute unit with bit-serial shifter
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 5
) (
    input  logic         i_clk,
    input  logic         i_arstn,
    alu_seq_exec_if.slave bus
);

    exec_state_e       state;
    logic [CTRL_W-1:0] ctrl_q;
    logic [XLEN-1:0]   shreg;
    logic [SHAMT_W-1:0] cnt;

    logic [XLEN-1:0]    comb_result;
    logic [SHAMT_W-1:0] req_shamt;
    logic [XLEN-1:0]    load_val;
    logic [XLEN-1:0]    load_final;
    logic [XLEN-1:0]    step_val;
    logic [XLEN-1:0]    step_final;

    alu_comb_unit #(
        .XLEN   (XLEN),
        .CTRL_W (CTRL_W)
    ) u_comb (
        .alu_control (bus.i_alu_control),
        .src_a       (bus.i_src_a),
        .src_b       (bus.i_src_b),
        .result      (comb_result)
    );

    always_comb begin
        req_shamt = bus.i_src_b[SHAMT_W-1:0];
        if (is_w_shift(bus.i_alu_control)) begin
            req_shamt = {1'b0, bus.i_src_b[SHAMT_W_W-1:0]};
        end

        // Pre-extending the W sources lets the 64-bit right shifts fill correctly.
        load_val = bus.i_src_a;
        case (bus.i_alu_control)
            ALU_SRLW: load_val = {{(XLEN-32){1'b0}}, bus.i_src_a[31:0]};
            ALU_SRAW: load_val = sext_w(bus.i_src_a);
            default:  load_val = bus.i_src_a;
        endcase

        load_final = is_w_op(bus.i_alu_control) ? sext_w(load_val) : load_val;
        step_val   = shift_one(ctrl_q, shreg);
        step_final = is_w_op(ctrl_q) ? sext_w(step_val) : step_val;
    end

    always_ff @(posedge i_clk or negedge i_arstn) begin
        if (!i_arstn) begin
            state        <= IDLE;
            bus.o_ready  <= 1'b1;
            bus.o_valid  <= 1'b0;
            bus.o_result <= '0;
            bus.o_zero   <= 1'b1;
            ctrl_q       <= '0;
            shreg        <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        bus.o_ready <= 1'b0;
                        ctrl_q      <= bus.i_alu_control;
                        if (!is_shift_op(bus.i_alu_control)) begin
                            bus.o_result <= comb_result;
                            bus.o_zero   <= (comb_result == '0);
                            bus.o_valid  <= 1'b1;
                            state        <= DONE;
                        end else if (req_shamt == '0) begin
                            bus.o_result <= load_final;
                            bus.o_zero   <= (load_final == '0);
                            bus.o_valid  <= 1'b1;
                            state        <= DONE;
                        end else begin
                            shreg <= load_val;
                            cnt   <= req_shamt;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    shreg <= step_val;
                    cnt   <= cnt - 1'b1;
                    if (cnt == SHAMT_W'(1)) begin
                        bus.o_result <= step_final;
                        bus.o_zero   <= (step_final == '0);
                        bus.o_valid  <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        bus.o_valid <= 1'b0;
                        bus.o_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    bus.o_valid <= 1'b0;
                    bus.o_ready <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb/tb_alu_seq_exec.sv - directed and random checks of alu_seq_exec against a reference model
module tb_alu_seq_exec;

    logic clk;
    logic arstn;
    int   vectors;
    int   miscompares;

    alu_seq_exec_if #(.XLEN(64), .CTRL_W(5)) bus ();

    alu_seq_exec #(.XLEN(64), .CTRL_W(5)) dut (
        .i_clk   (clk),
        .i_arstn (arstn),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] sx32(input logic [31:0] w);
        return {{32{w[31]}}, w};
    endfunction

    function automatic logic [63:0] ref_alu(input logic [4:0] c, input logic [63:0] a,
                                            input logic [63:0] b);
        logic [31:0] w;
        logic [63:0] r;
        r = 64'd0;
        case (c)
            5'd0:        r = a + b;
            5'd1:        r = a - b;
            5'd2:        r = a & b;
            5'd3:        r = a | b;
            5'd4:        r = a ^ b;
            5'd5, 5'd10: r = a << b[5:0];
            5'd6:        r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            5'd7:        r = (a < b) ? 64'd1 : 64'd0;
            5'd8, 5'd11: r = a >> b[5:0];
            5'd9, 5'd12: r = $signed(a) >>> b[5:0];
            5'd13, 5'd18: begin w = a[31:0] + b[31:0]; r = sx32(w); end
            5'd14:       begin w = a[31:0] - b[31:0]; r = sx32(w); end
            5'd15:       begin w = a[31:0] << b[4:0]; r = sx32(w); end
            5'd16:       begin w = a[31:0] >> b[4:0]; r = sx32(w); end
            5'd17:       begin w = $signed(a[31:0]) >>> b[4:0]; r = sx32(w); end
            default:     r = 64'd0;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [4:0] c, input logic [63:0] b);
        case (c)
            5'd5, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12: return 1 + int'(b[5:0]);
            5'd15, 5'd16, 5'd17:                   return 1 + int'(b[4:0]);
            default:                               return 1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic run_op(input logic [4:0] c, input logic [63:0] a, input logic [63:0] b,
                          input int hold, input string tag);
        logic [63:0] exp_r;
        int          exp_lat;
        int          lat;
        exp_r   = ref_alu(c, a, b);
        exp_lat = ref_lat(c, b);
        check({tag, ".ready_before"}, 64'(bus.o_ready), 64'd1);
        bus.i_valid       = 1'b1;
        bus.i_alu_control = c;
        bus.i_src_a       = a;
        bus.i_src_b       = b;
        @(negedge clk);
        bus.i_valid       = 1'b0;
        bus.i_alu_control = 5'($urandom());
        bus.i_src_a       = {$urandom(), $urandom()};
        bus.i_src_b       = {$urandom(), $urandom()};
        lat = 0;
        for (int k = 1; k <= 80; k++) begin
            if (bus.o_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".result"}, bus.o_result, exp_r);
        check({tag, ".zero"}, 64'(bus.o_zero), 64'(exp_r == 64'd0));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check({tag, ".hold_valid"}, 64'(bus.o_valid), 64'd1);
            check({tag, ".hold_result"}, bus.o_result, exp_r);
            check({tag, ".hold_zero"}, 64'(bus.o_zero), 64'(exp_r == 64'd0));
        end
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        check({tag, ".valid_drop"}, 64'(bus.o_valid), 64'd0);
        check({tag, ".ready_back"}, 64'(bus.o_ready), 64'd1);
    endtask

    initial begin
        logic [4:0]  rc;
        logic [63:0] ra;
        logic [63:0] rb;
        vectors           = 0;
        miscompares       = 0;
        arstn             = 1'b0;
        bus.i_valid       = 1'b0;
        bus.i_alu_control = 5'd0;
        bus.i_src_a       = 64'd0;
        bus.i_src_b       = 64'd0;
        bus.i_ready       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.ready", 64'(bus.o_ready), 64'd1);
        check("rst.valid", 64'(bus.o_valid), 64'd0);
        check("rst.result", bus.o_result, 64'd0);
        check("rst.zero", 64'(bus.o_zero), 64'd1);
        arstn = 1'b1;
        @(negedge clk);

        run_op(5'd0,  64'd5, 64'd7, 0, "add");
        run_op(5'd1,  64'h1234, 64'h1234, 3, "sub_hold");
        run_op(5'd9,  64'h8000_0000_0000_0000, 64'd4, 0, "sra");
        run_op(5'd16, 64'h0000_0000_8000_0000, 64'd0, 0, "srlw_b0");
        run_op(5'd16, 64'h0000_0000_8000_0000, 64'd1, 0, "srlw_b1");
        run_op(5'd13, 64'h7FFF_FFFF, 64'd1, 0, "addw");
        run_op(5'd7,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "sltu");
        run_op(5'd6,  64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 0, "slt");
        run_op(5'd17, 64'h0000_0000_8000_0010, 64'd35, 1, "sraw_b35");
        run_op(5'd5,  64'h1, 64'd63, 0, "sll_63");
        run_op(5'd21, 64'd3, 64'd4, 0, "illegal");

        // Abort a long shift with an asynchronous reset.
        check("abort.ready_before", 64'(bus.o_ready), 64'd1);
        bus.i_valid       = 1'b1;
        bus.i_alu_control = 5'd5;
        bus.i_src_a       = 64'hDEAD_BEEF;
        bus.i_src_b       = 64'd63;
        @(negedge clk);
        bus.i_valid = 1'b0;
        repeat (9) @(negedge clk);
        arstn = 1'b0;
        #1;
        check("abort.valid", 64'(bus.o_valid), 64'd0);
        check("abort.ready", 64'(bus.o_ready), 64'd1);
        check("abort.result", bus.o_result, 64'd0);
        check("abort.zero", 64'(bus.o_zero), 64'd1);
        @(negedge clk);
        arstn = 1'b1;
        repeat (3) @(negedge clk);
        check("abort.no_output", 64'(bus.o_valid), 64'd0);
        run_op(5'd0, 64'd1, 64'd1, 0, "add_after_rst");

        for (int n = 0; n < 40; n++) begin
            rc = 5'($urandom_range(22, 0));
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if (n % 4 == 0) ra = rb;
            run_op(rc, ra, rb, int'($urandom_range(2, 0)), $sformatf("rnd%0d_c%0d", n, rc));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
